c_vector_packer: RTL and testbench

Sequential packer that collects a stream of 2-bit signed C elements, one per cycle, into LANES-wide C0/C1 bit-plane vectors. It presents each completed vector downstream on a valid/ready interface. It sits directly in front of the C adder tree: its C0/C1 outputs connect to the tree's C0/C1 inputs. It also emits its own running signed sum, which verification cross-checks against the tree's SUM.

---
 rtl/c_vector_packer.sv | 166 ++++++++++++++++
 tb/tb_c_vector_packer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/c_vector_packer.sv
// c_vector_packer: packs a stream of 2-bit signed elements into LANES-wide
// C0/C1 bit-plane vectors with a running signed sum. A fill stage collects
// elements while a separate output register presents the previous vector,
// so input keeps flowing across vector boundaries while downstream is ready.
module c_vector_packer #(
    parameter int LANES = 32,
    localparam int CNT_W = $clog2(LANES) + 1,
    localparam int SUM_W = $clog2(LANES) + 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       IN_C,
    input  logic             IN_LAST,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [LANES-1:0] C0,
    output logic [LANES-1:0] C1,
    output logic [SUM_W-1:0] OUT_SUM,
    output logic [CNT_W-1:0] OUT_CNT
);

    localparam int IDX_W = $clog2(LANES);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Sign-extend one {C1,C0} element to accumulator width.
    function automatic logic signed [SUM_W-1:0] sext_elem(input logic [1:0] c);
        sext_elem = {{(SUM_W-2){c[1]}}, c};
    endfunction

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [LANES-1:0]        fill_c0_r;
    logic [LANES-1:0]        fill_c1_r;
    logic [CNT_W-1:0]        cnt_r;
    logic signed [SUM_W-1:0] acc_r;

    logic [LANES-1:0]        out_c0_r;
    logic [LANES-1:0]        out_c1_r;
    logic [SUM_W-1:0]        out_sum_r;
    logic [CNT_W-1:0]        out_cnt_r;
    logic                    out_valid_r;

    logic                    in_ready_s;
    logic                    accept_s;
    logic                    slot_free_s;
    logic                    complete_s;
    logic                    transfer_s;
    logic [IDX_W-1:0]        lane_idx_s;
    logic [LANES-1:0]        nxt_c0_s;
    logic [LANES-1:0]        nxt_c1_s;
    logic signed [SUM_W-1:0] nxt_acc_s;
    logic [CNT_W-1:0]        nxt_cnt_s;

    // Ready depends on state only, so OUT_READY never reaches IN_READY combinationally.
    assign in_ready_s  = (state_r == FILL);
    assign accept_s    = IN_VALID & in_ready_s;
    assign slot_free_s = ~out_valid_r | OUT_READY;
    assign complete_s  = accept_s & ((cnt_r == CNT_W'(LANES - 1)) | IN_LAST);
    assign lane_idx_s  = cnt_r[IDX_W-1:0];

    // Fill contents including the element accepted this cycle (if any).
    always_comb begin
        nxt_c0_s  = fill_c0_r;
        nxt_c1_s  = fill_c1_r;
        nxt_acc_s = acc_r;
        nxt_cnt_s = cnt_r;
        if (accept_s) begin
            nxt_c0_s[lane_idx_s] = IN_C[0];
            nxt_c1_s[lane_idx_s] = IN_C[1];
            nxt_acc_s            = acc_r + sext_elem(IN_C);
            nxt_cnt_s            = cnt_r + CNT_W'(1);
        end else begin
            nxt_cnt_s = cnt_r;
        end
    end

    // Next-state and transfer decision: completion or HOLD moves fill to output when the slot frees.
    always_comb begin
        state_nxt_s = state_r;
        transfer_s  = 1'b0;
        case (state_r)
            FILL: begin
                transfer_s = complete_s & slot_free_s;
                if (complete_s && !slot_free_s) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = FILL;
                end
            end
            HOLD: begin
                transfer_s = slot_free_s;
                if (slot_free_s) begin
                    state_nxt_s = FILL;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = FILL;
                transfer_s  = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= FILL;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Fill stage: clears on transfer, otherwise absorbs each accepted element.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fill_c0_r <= {LANES{1'b0}};
            fill_c1_r <= {LANES{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            acc_r     <= {SUM_W{1'b0}};
        end else if (transfer_s) begin
            fill_c0_r <= {LANES{1'b0}};
            fill_c1_r <= {LANES{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            acc_r     <= {SUM_W{1'b0}};
        end else if (accept_s) begin
            fill_c0_r <= nxt_c0_s;
            fill_c1_r <= nxt_c1_s;
            cnt_r     <= nxt_cnt_s;
            acc_r     <= nxt_acc_s;
        end
    end

    // Output register: loads on transfer, drops valid on a plain consume, contents otherwise hold.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_c0_r    <= {LANES{1'b0}};
            out_c1_r    <= {LANES{1'b0}};
            out_sum_r   <= {SUM_W{1'b0}};
            out_cnt_r   <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
        end else if (transfer_s) begin
            out_c0_r    <= nxt_c0_s;
            out_c1_r    <= nxt_c1_s;
            out_sum_r   <= nxt_acc_s;
            out_cnt_r   <= nxt_cnt_s;
            out_valid_r <= 1'b1;
        end else if (out_valid_r && OUT_READY) begin
            out_valid_r <= 1'b0;
        end
    end

    assign IN_READY  = in_ready_s;
    assign OUT_VALID = out_valid_r;
    assign C0        = out_c0_r;
    assign C1        = out_c1_r;
    assign OUT_SUM   = out_sum_r;
    assign OUT_CNT   = out_cnt_r;

endmodule

// File: tb/tb_c_vector_packer.sv
// Directed and scoreboarded random bench for c_vector_packer (LANES=32).
module tb_c_vector_packer;

    logic        CLK;
    logic        RST_N;
    logic        IN_VALID;
    logic        IN_READY;
    logic [1:0]  IN_C;
    logic        IN_LAST;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] C0;
    logic [31:0] C1;
    logic [6:0]  OUT_SUM;
    logic [5:0]  OUT_CNT;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] c0;
        logic [31:0] c1;
        logic [6:0]  sum;
        logic [5:0]  cnt;
    } vec_t;

    vec_t        exp_q[$];
    vec_t        ev;
    logic [31:0] cur_c0;
    logic [31:0] cur_c1;
    logic [6:0]  cur_sum;
    int          cur_cnt;
    logic        stalled;
    logic [79:0] prev_out;

    c_vector_packer #(.LANES(32)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_C      (IN_C),
        .IN_LAST   (IN_LAST),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .C0        (C0),
        .C1        (C1),
        .OUT_SUM   (OUT_SUM),
        .OUT_CNT   (OUT_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] c0,
                             input logic [31:0] c1, input logic [6:0] s, input logic [5:0] n);
        check({tag, "_valid"}, OUT_VALID, v);
        check({tag, "_c0"}, C0, c0);
        check({tag, "_c1"}, C1, c1);
        check({tag, "_sum"}, OUT_SUM, s);
        check({tag, "_cnt"}, OUT_CNT, n);
    endtask

    task automatic send(input logic [1:0] c, input logic last);
        IN_VALID = 1'b1;
        IN_C     = c;
        IN_LAST  = last;
        tick();
        IN_VALID = 1'b0;
        IN_LAST  = 1'b0;
    endtask

    // Scoreboard: compare a consumed vector with the oldest expected one.
    task automatic sb_consume();
        if (OUT_VALID && OUT_READY) begin
            check("sb_nonempty", (exp_q.size() > 0), 1'b1);
            if (exp_q.size() > 0) begin
                ev = exp_q.pop_front();
                check("sb_vec", {3'b000, C0, C1, OUT_SUM, OUT_CNT}, {3'b000, ev.c0, ev.c1, ev.sum, ev.cnt});
            end
        end
    endtask

    initial begin
        RST_N     = 1'b0;
        IN_VALID  = 1'b0;
        IN_C      = 2'b00;
        IN_LAST   = 1'b0;
        OUT_READY = 1'b0;
        stalled   = 1'b0;
        prev_out  = 80'd0;
        cur_c0    = 32'd0;
        cur_c1    = 32'd0;
        cur_sum   = 7'd0;
        cur_cnt   = 0;

        // Reset state
        #12;
        check("rst_rdy", IN_READY, 1'b1);
        check_out("rst", 1'b0, 32'h0, 32'h0, 7'h00, 6'd0);
        RST_N = 1'b1;
        tick();

        // 32 x (+1), downstream ready
        OUT_READY = 1'b1;
        for (int i = 0; i < 32; i++) begin
            check("t1_rdy", IN_READY, 1'b1);
            if (i == 31) check("t1_early", OUT_VALID, 1'b0);
            send(2'b01, 1'b0);
        end
        check_out("t1", 1'b1, 32'hFFFF_FFFF, 32'h0, 7'h20, 6'd32);

        // 32 x (-2) then 32 x (-1) back to back
        for (int i = 0; i < 32; i++) begin
            check("t2_rdy", IN_READY, 1'b1);
            IN_VALID = 1'b1;
            IN_C     = 2'b10;
            tick();
        end
        check_out("t2a", 1'b1, 32'h0, 32'hFFFF_FFFF, 7'h40, 6'd32);
        for (int i = 0; i < 32; i++) begin
            check("t2_rdy2", IN_READY, 1'b1);
            IN_VALID = 1'b1;
            IN_C     = 2'b11;
            tick();
        end
        IN_VALID = 1'b0;
        check_out("t2b", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'h60, 6'd32);

        // Early close with IN_LAST, then the next element starts at lane 0
        tick();
        check("t3_consumed", OUT_VALID, 1'b0);
        send(2'b01, 1'b0);
        send(2'b11, 1'b0);
        send(2'b10, 1'b0);
        send(2'b00, 1'b0);
        send(2'b01, 1'b1);
        check_out("t3a", 1'b1, 32'h0000_0013, 32'h0000_0006, 7'h7F, 6'd5);
        send(2'b11, 1'b1);
        check_out("t3b", 1'b1, 32'h0000_0001, 32'h0000_0001, 7'h7F, 6'd1);

        // Backpressure: 64 elements fill both stages
        tick();
        OUT_READY = 1'b0;
        check("t4_empty", OUT_VALID, 1'b0);
        for (int i = 0; i < 32; i++) send(2'b01, 1'b0);
        for (int i = 0; i < 32; i++) begin
            if (i == 0) check_out("t4_first", 1'b1, 32'hFFFF_FFFF, 32'h0, 7'h20, 6'd32);
            check("t4_rdy", IN_READY, 1'b1);
            send(2'b11, 1'b0);
        end
        check("t4_stall_rdy", IN_READY, 1'b0);
        check_out("t4_hold", 1'b1, 32'hFFFF_FFFF, 32'h0, 7'h20, 6'd32);
        IN_VALID = 1'b1;
        IN_C     = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_blk_rdy", IN_READY, 1'b0);
            check_out("t4_stable", 1'b1, 32'hFFFF_FFFF, 32'h0, 7'h20, 6'd32);
        end
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        IN_VALID  = 1'b0;
        check("t4_rel_rdy", IN_READY, 1'b1);
        check_out("t4_rel", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'h60, 6'd32);
        tick();
        check_out("t4_keep", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'h60, 6'd32);
        OUT_READY = 1'b1;
        send(2'b01, 1'b1);
        check_out("t4_after", 1'b1, 32'h1, 32'h0, 7'h01, 6'd1);

        // Reset mid-vector
        for (int i = 0; i < 10; i++) send(2'b10, 1'b0);
        #1 RST_N = 1'b0;
        #1;
        check("t5_rst_rdy", IN_READY, 1'b1);
        check_out("t5_rst", 1'b0, 32'h0, 32'h0, 7'h00, 6'd0);
        #1 RST_N = 1'b1;
        for (int i = 0; i < 32; i++) send(2'b01, 1'b0);
        check_out("t5", 1'b1, 32'hFFFF_FFFF, 32'h0, 7'h20, 6'd32);
        tick();
        tick();

        // Random traffic against a transaction scoreboard
        for (int i = 0; i < 4000; i++) begin
            if (stalled) check("rnd_stable", {3'b000, C0, C1, OUT_SUM, OUT_CNT}, prev_out);
            IN_VALID  = ($urandom_range(0, 3) != 0);
            IN_C      = 2'($urandom_range(0, 3));
            IN_LAST   = ($urandom_range(0, 9) == 0);
            OUT_READY = (i % 512 < 256) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 5) == 0);
            sb_consume();
            if (IN_VALID && IN_READY) begin
                cur_c0[cur_cnt] = IN_C[0];
                cur_c1[cur_cnt] = IN_C[1];
                cur_sum         = cur_sum + {{5{IN_C[1]}}, IN_C};
                cur_cnt++;
                if (cur_cnt == 32 || IN_LAST) begin
                    ev.c0  = cur_c0;
                    ev.c1  = cur_c1;
                    ev.sum = cur_sum;
                    ev.cnt = 6'(cur_cnt);
                    exp_q.push_back(ev);
                    cur_c0  = 32'd0;
                    cur_c1  = 32'd0;
                    cur_sum = 7'd0;
                    cur_cnt = 0;
                end
            end
            stalled  = OUT_VALID && !OUT_READY;
            prev_out = {3'b000, C0, C1, OUT_SUM, OUT_CNT};
            tick();
        end
        IN_VALID  = 1'b0;
        IN_LAST   = 1'b0;
        OUT_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sb_consume();
            tick();
        end
        check("sb_drained", exp_q.size(), 80'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
